// File: rtl/tone_pkg.sv
// Shared definitions for the Goertzel tone detection path: calc FSM states,
// datapath widths and the Q2.14 bin coefficients used by the transcription back end.
package tone_pkg;

  typedef enum logic [2:0] {
    C_IDLE  = 3'd0,
    C_S1SQ  = 3'd1,
    C_S2SQ  = 3'd2,
    C_CPROD = 3'd3,
    C_CROSS = 3'd4,
    C_OUT   = 3'd5
  } calc_state_t;

  localparam int SAMPLE_W   = 8;
  localparam int STATE_W    = 20;
  localparam int ACC_W      = 48;
  localparam int COEFF_FRAC = 14;

  // 2*cos(2*pi*f/12000) in Q2.14 for the note bins of interest
  localparam logic signed [15:0] COEFF_750HZ = 16'sd30274;
  localparam logic signed [15:0] COEFF_440HZ = 16'sd31902;

endpackage

// File: rtl/goertzel_power.sv
// Goertzel bin power from the final recursion state, using one shared multiplier
// across a five-step sequence, with clamping of the 48-bit result into 32 bits.
module goertzel_power
  import tone_pkg::*;
#(
  parameter logic signed [15:0] COEFF     = COEFF_750HZ,
  parameter logic        [31:0] THRESHOLD = 32'd4194304
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      kick,
  input  logic signed [STATE_W-1:0] f1,
  input  logic signed [STATE_W-1:0] f2,
  output logic [31:0]               power_out,
  output logic                      power_valid_out,
  output logic                      detect_out
);

  calc_state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic signed [21:0]      p;
  logic signed [23:0]      mul_a;
  logic signed [23:0]      mul_b;
  logic signed [47:0]      mul_y;

  // Negative power can only come from rounding of the cross term; it clamps to 0
  function automatic logic [31:0] sat_power(input logic signed [ACC_W-1:0] a);
    if (a < 0)
      return 32'd0;
    else if (a > 48'sh0000_FFFF_FFFF)
      return 32'hFFFF_FFFF;
    else
      return a[31:0];
  endfunction

  // Shared multiplier operand selection by calc step
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      C_S1SQ:  begin mul_a = 24'(f1);    mul_b = 24'(f1); end
      C_S2SQ:  begin mul_a = 24'(f2);    mul_b = 24'(f2); end
      C_CPROD: begin mul_a = 24'(COEFF); mul_b = 24'(f1); end
      C_CROSS: begin mul_a = 24'(p);     mul_b = 24'(f2); end
      default: begin mul_a = '0;         mul_b = '0;      end
    endcase
  end

  assign mul_y = 48'(mul_a) * 48'(mul_b);

  // Calc FSM next state: one pass through the steps per kick
  always_comb begin
    state_nxt = state;
    case (state)
      C_IDLE:  if (kick) state_nxt = C_S1SQ;
      C_S1SQ:  state_nxt = C_S2SQ;
      C_S2SQ:  state_nxt = C_CPROD;
      C_CPROD: state_nxt = C_CROSS;
      C_CROSS: state_nxt = C_OUT;
      C_OUT:   state_nxt = C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
  end

  // Calc FSM state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      state <= C_IDLE;
    else
      state <= state_nxt;
  end

  // Accumulate s1^2 + s2^2 - c*s1*s2 and publish the clamped result
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc             <= '0;
      p               <= '0;
      power_out       <= '0;
      power_valid_out <= 1'b0;
      detect_out      <= 1'b0;
    end else begin
      power_valid_out <= 1'b0;
      case (state)
        C_S1SQ:  acc <= mul_y;
        C_S2SQ:  acc <= acc + mul_y;
        C_CPROD: p   <= 22'(mul_y >>> COEFF_FRAC);
        C_CROSS: acc <= acc - mul_y;
        C_OUT: begin
          power_out       <= sat_power(acc);
          detect_out      <= (sat_power(acc) >= THRESHOLD);
          power_valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/goertzel_tone_detector.sv
// Single-bin Goertzel tone detector: runs the recursion over blocks of N_SAMPLES
// samples, snapshots the final state and hands it to the power calculation.
module goertzel_tone_detector
  import tone_pkg::*;
#(
  parameter int                 N_SAMPLES = 96,
  parameter logic signed [15:0] COEFF     = 16'sd30274,
  parameter logic        [31:0] THRESHOLD = 32'd4194304
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       sample_valid_in,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic [31:0]                power_out,
  output logic                       power_valid_out,
  output logic                       detect_out
);

  localparam int CNT_W = $clog2(N_SAMPLES);

  logic signed [STATE_W-1:0] s1, s2, s0;
  logic signed [STATE_W-1:0] f1, f2;
  logic        [CNT_W-1:0]   cnt;
  logic signed [35:0]        prod;
  logic signed [35:0]        s0_wide;
  logic                      last;
  logic                      kick;

  // Recursion step; truncation to STATE_W gives the intended wrap on overflow
  always_comb begin
    prod    = 36'(COEFF) * 36'(s1);
    s0_wide = 36'(sample_in) + (prod >>> COEFF_FRAC) - 36'(s2);
    s0      = s0_wide[STATE_W-1:0];
  end

  assign last = (cnt == CNT_W'(N_SAMPLES - 1));
  assign kick = sample_valid_in && last;

  // Accumulator, block counter and end-of-block snapshot
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1  <= '0;
      s2  <= '0;
      f1  <= '0;
      f2  <= '0;
      cnt <= '0;
    end else if (sample_valid_in) begin
      if (last) begin
        f1  <= s0;
        f2  <= s1;
        s1  <= '0;
        s2  <= '0;
        cnt <= '0;
      end else begin
        s2  <= s1;
        s1  <= s0;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  goertzel_power #(
    .COEFF     (COEFF),
    .THRESHOLD (THRESHOLD)
  ) u_power (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .kick            (kick),
    .f1              (f1),
    .f2              (f2),
    .power_out       (power_out),
    .power_valid_out (power_valid_out),
    .detect_out      (detect_out)
  );

endmodule

// File: tb/tb_goertzel_tone_detector.sv
// Bench for goertzel_tone_detector: block-level reference model plus directed tones.
module tb_goertzel_tone_detector;

  localparam int     N      = 96;
  localparam longint COEF   = 30274;
  localparam longint THR    = 4194304;
  localparam real    PI     = 3.14159265358979;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              sample_valid_in;
  logic signed [7:0] sample_in;
  logic [31:0]       power_out;
  logic              power_valid_out;
  logic              detect_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int     due;
    longint pw;
    longint det;
  } exp_t;

  exp_t   exp_q[$];
  int     blk[$];
  int     ecount = 0;
  int     last_accept_edge = 0;
  int     npulses = 0;
  int     pulse_edge = 0;
  int     pulse_edge_prev = 0;
  longint last_power = 0;
  longint last_detect = 0;
  longint prev_detect = 0;
  longint held_p = 0;
  longint held_d = 0;

  goertzel_tone_detector dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_valid_in (sample_valid_in),
    .sample_in       (sample_in),
    .power_out       (power_out),
    .power_valid_out (power_valid_out),
    .detect_out      (detect_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic longint wrap(input longint v, input int w);
    longint m;
    m = v & ((64'sd1 <<< w) - 1);
    if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
    return m;
  endfunction

  // Bin power of one complete block, straight from the Goertzel definition
  function automatic longint goertzel_ref(input int xs[$]);
    longint a = 0, b = 0, c, p, acc;
    foreach (xs[i]) begin
      c = wrap(longint'(xs[i]) + ((COEF * a) >>> 14) - b, 20);
      b = a;
      a = c;
    end
    p   = wrap((COEF * a) >>> 14, 22);
    acc = a * a + b * b - p * b;
    if (acc < 0) return 0;
    if (acc > 64'sh0_FFFF_FFFF) return 64'sh0_FFFF_FFFF;
    return acc;
  endfunction

  function automatic int tone750(input int n, input int amp);
    return int'(real'(amp) * $sin(2.0 * PI * real'(n) / 16.0));
  endfunction

  // Reference model: collect samples per block, schedule the result 5 edges later
  always @(posedge clk_in) begin
    exp_t e;
    ecount++;
    if (rst_in) begin
      blk.delete();
      exp_q.delete();
    end else if (sample_valid_in) begin
      blk.push_back(int'(sample_in));
      if (blk.size() == N) begin
        e.due = ecount + 5;
        e.pw  = goertzel_ref(blk);
        e.det = (e.pw >= THR) ? 1 : 0;
        exp_q.push_back(e);
        last_accept_edge = ecount;
        blk.delete();
      end
    end
  end

  // Compare outputs against the model every cycle, away from the active edge
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in) begin
      check("rst_power", power_out, 0);
      check("rst_valid", power_valid_out, 0);
      check("rst_detect", detect_out, 0);
      held_p = 0;
      held_d = 0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == ecount) begin
        e = exp_q.pop_front();
        check("pulse_valid", power_valid_out, 1);
        check("pulse_power", power_out, e.pw);
        check("pulse_detect", detect_out, e.det);
        held_p = e.pw;
        held_d = e.det;
      end else begin
        check("idle_valid", power_valid_out, 0);
        check("hold_power", power_out, held_p);
        check("hold_detect", detect_out, held_d);
      end
      if (power_valid_out) begin
        npulses++;
        pulse_edge_prev = pulse_edge;
        pulse_edge      = ecount;
        prev_detect     = last_detect;
        last_power      = power_out;
        last_detect     = detect_out;
      end
    end
  end

  task automatic send(input int v);
    sample_valid_in = 1'b1;
    sample_in       = 8'(v);
    @(posedge clk_in);
    #1;
    sample_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    int          np;
    longint      onbin_power;
    int          q[$];
    bit [31:0]   ph;
    int          kind, amp, cval;

    rst_in          = 1'b1;
    sample_valid_in = 1'b0;
    sample_in       = '0;
    repeat (4) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    idle(3);
    check("reset_no_pulse", npulses, 0);
    check("reset_power", power_out, 0);

    // Model pinned against hand expectations of the 750 Hz and silent blocks
    q.delete();
    for (int n = 0; n < N; n++) q.push_back(tone750(n, 127));
    check("model_onbin_in_range",
          (goertzel_ref(q) >= 33300000 && goertzel_ref(q) <= 40700000) ? 1 : 0, 1);
    q.delete();
    for (int n = 0; n < N; n++) q.push_back(0);
    check("model_silence", goertzel_ref(q), 0);

    // On-bin tone
    for (int n = 0; n < N; n++) send(tone750(n, 127));
    idle(8);
    check("onbin_pulses", npulses, 1);
    check("onbin_latency", pulse_edge - last_accept_edge, 5);
    check("onbin_power_range", (last_power >= 33300000 && last_power <= 40700000) ? 1 : 0, 1);
    check("onbin_detect", last_detect, 1);
    onbin_power = last_power;

    // Off-bin 440 Hz tone
    ph = 32'd0;
    for (int n = 0; n < N; n++) begin
      send(int'(127.0 * $sin(2.0 * PI * real'(ph) / 4294967296.0)));
      ph = ph + 32'h0963_3A1B;
    end
    idle(8);
    check("offbin_pulses", npulses, 2);
    check("offbin_below_thr", (last_power < THR) ? 1 : 0, 1);
    check("offbin_detect", last_detect, 0);

    // Silence
    for (int n = 0; n < N; n++) send(0);
    idle(8);
    check("silence_power", last_power, 0);
    check("silence_detect", last_detect, 0);

    // Back-to-back blocks: tone then silence, no gap
    np = npulses;
    for (int n = 0; n < N; n++) send(tone750(n, 127));
    for (int n = 0; n < N; n++) send(0);
    idle(8);
    check("b2b_pulses", npulses - np, 2);
    check("b2b_spacing", pulse_edge - pulse_edge_prev, 96);
    check("b2b_first_detect", prev_detect, 1);
    check("b2b_second_power", last_power, 0);
    check("b2b_second_detect", last_detect, 0);

    // Mid-block reset with a detection showing on the outputs
    for (int n = 0; n < N; n++) send(tone750(n, 127));
    for (int n = 0; n < 50; n++) send(tone750(n, 127));
    check("pre_rst_detect", detect_out, 1);
    rst_in = 1'b1;
    #1;
    check("midrst_power", power_out, 0);
    check("midrst_detect", detect_out, 0);
    check("midrst_valid", power_valid_out, 0);
    idle(2);
    rst_in = 1'b0;
    idle(2);
    np = npulses;
    for (int n = 0; n < N; n++) send(tone750(n, 127));
    idle(8);
    check("postrst_pulses", npulses - np, 1);
    check("postrst_power_same", last_power, onbin_power);
    check("postrst_detect", last_detect, 1);

    // Randomized blocks with gaps in sample_valid_in
    for (int b = 0; b < 10; b++) begin
      kind = $urandom_range(0, 2);
      amp  = $urandom_range(20, 127);
      cval = int'($urandom_range(0, 255)) - 128;
      for (int n = 0; n < N; n++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        case (kind)
          0:       send(int'($urandom_range(0, 255)) - 128);
          1:       send(tone750(n, amp));
          default: send(cval);
        endcase
      end
    end
    idle(10);
    check("all_results_seen", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/goertzel_tone_detector.md
# goertzel_tone_detector

Single-bin tone detector that consumes the 8-bit signed sample stream produced by the sine generators or the audio front end. It runs a Goertzel recursion over fixed blocks of N samples and reports the squared magnitude of one DFT bin, along with a threshold decision. It is the receiving end of the tone path: generators synthesize notes, and this block decides whether a given note is present. One instance is used per note of interest in the transcription back end.

## Interface
- N_SAMPLES, 96: samples per analysis block. Legal range 8..128.
- COEFF, 16'sd30274: 2·cos(2πk/N) as signed Q2.14. The default selects bin k=6, which is 750 Hz at a 12 kHz sample rate.
- THRESHOLD, 32'd4194304: `detect_out` asserts when `power_out` is greater than or equal to this value.
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- sample_valid_in  input  1  qualifies `sample_in`; at most one sample per cycle
- sample_in  input  8  signed two's-complement audio sample
- power_out  output  32  unsigned bin power of the last completed block
- power_valid_out  output  1  one-cycle pulse when `power_out` and `detect_out` update
- detect_out  output  1  level output; equals `power_out >= THRESHOLD`

## Operation
**Accumulator.** Registers s1 and s2 are signed 20-bit, and the sample counter runs 0..N_SAMPLES-1.
- On each clock with `sample_valid_in` high:
  - s0 = sample_in + ((COEFF·s1) >>> 14) − s2, with sign extension and an arithmetic shift.
  - s2 ← s1, s1 ← s0, counter increments.
- On the sample where the counter equals N_SAMPLES-1:
  - f1 ← s0 and f2 ← s1, snapshotting the final state.
  - s1 and s2 clear to 0, the counter wraps to 0, and the calc FSM is kicked.
- The next block starts on the very next valid sample, with no gap.
- s1 and s2 wrap on overflow; there is no saturation. 20 bits is sufficient for the default parameters at full-scale input.

**Calc FSM.** It runs on f1/f2 using one shared multiplier, independent of the accumulator. The accumulator acc is signed 48-bit.
- C_IDLE: wait for the kick.
- C_S1SQ: acc ← f1·f1.
- C_S2SQ: acc ← acc + f2·f2.
- C_CPROD: p ← (COEFF·f1) >>> 14, where p is signed 22-bit.
- C_CROSS: acc ← acc − p·f2.
- C_OUT: register the outputs, pulse `power_valid_out`, then return to C_IDLE.

**Output rules.**
- `power_out` = 0 if acc < 0, 32'hFFFF_FFFF if acc > 2^32−1, otherwise acc[31:0].
- `detect_out` is recomputed only in C_OUT and holds its value between blocks.
- A kick while the FSM is not in C_IDLE cannot occur, because N_SAMPLES ≥ 8 exceeds the calc length of 5 cycles.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `power_out` = 0, `power_valid_out` = 0, `detect_out` = 0.
  - s1, s2, f1, f2, acc and the counter are cleared; FSM is in C_IDLE.
- Reset released mid-block: the partial block is discarded, and counting restarts from sample 0.
- Latency: call the clock edge that accepts the last sample of a block E0. `power_valid_out` is high for exactly the cycle after edge E5, and `power_out` and `detect_out` are valid in that same cycle.
- Concurrency: samples arriving during C_S1SQ..C_OUT are accumulated normally, and the calc does not stall the input.
- Throughput: one sample per clock sustained. Results are spaced at least N_SAMPLES cycles apart.
- `sample_valid_in` low: the accumulator and counter hold their values.

## Structure
- Shared package `tone_pkg`:
  - Calc FSM state enum.
  - Widths: SAMPLE_W=8, STATE_W=20, ACC_W=48, COEFF_FRAC=14.
  - Default COEFF constants for the note bins used by the transcription back end, including 750 Hz and 440 Hz.
- Sub-module `goertzel_power`: the calc FSM, the shared multiplier and output saturation. The top level holds the accumulator, the counter and the snapshot registers.

## Test plan
- Reset: assert `rst_in` with no samples.
  - `power_out` = 0, `detect_out` = 0, and `power_valid_out` never pulses.
- On-bin tone: drive 96 consecutive samples of a 750 Hz amplitude-127 sine (16 samples per period), one per cycle.
  - Single `power_valid_out` pulse in the cycle after E5.
  - `power_out` ≈ 3.7e7 (±10%); `detect_out` = 1.
- Off-bin tone: drive 96 samples of a 440 Hz sine (phase increment 32'h0963_3A1B).
  - `power_out` < 4194304; `detect_out` = 0.
- Silence: drive 96 zero samples.
  - `power_out` = 0; `detect_out` = 0.
- Back-to-back blocks: 192 samples with `sample_valid_in` held high, the 750 Hz tone then silence.
  - Two pulses exactly 96 cycles apart: first `detect_out` = 1, second `power_out` = 0 and `detect_out` = 0.
- Mid-block reset: assert `rst_in` after 50 samples of the 750 Hz tone, release it, then drive a full 96-sample block.
  - All outputs zero immediately on reset.
  - The following result matches the on-bin tone case exactly.
